// File: rtl/mem_loader.sv
// Byte-stream memory loader: packs bytes little-endian into words, writes them, reads them back and sums them.
// Write one cycle after a word's 4th byte. Checksum takes each read word READ_LATENCY cycles after its address. byte_ready is high for the whole of LOAD; writes never stall.
module mem_loader #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_address,
  input  logic [15:0] word_count,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [31:0] write_address,
  output logic [31:0] write_data,
  output logic [3:0]  write_enable,
  output logic [31:0] read_address,
  input  logic [31:0] read_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] checksum
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_LOAD     = 2'd1;
  localparam logic [1:0] S_READBACK = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  logic [1:0]  state;
  logic [31:0] base;
  logic [15:0] count;
  logic [1:0]  lane;
  logic [23:0] partial;
  logic [15:0] wr_idx;
  logic [15:0] rd_idx;
  logic [15:0] smp_idx;
  logic [READ_LATENCY:0] rd_pipe;

  logic accept;
  logic last_word;
  logic issue;
  logic sample;

  assign accept    = byte_valid && byte_ready;
  assign last_word = (wr_idx == count - 16'd1);
  assign issue     = (state == S_READBACK) && (rd_idx != count);
  // rd_pipe[k] is high k cycles after a read address was presented
  assign sample    = rd_pipe[READ_LATENCY];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      base          <= 32'h0;
      count         <= 16'h0;
      lane          <= 2'd0;
      partial       <= 24'h0;
      wr_idx        <= 16'h0;
      rd_idx        <= 16'h0;
      smp_idx       <= 16'h0;
      rd_pipe       <= '0;
      byte_ready    <= 1'b0;
      write_address <= 32'h0;
      write_data    <= 32'h0;
      write_enable  <= 4'h0;
      read_address  <= 32'h0;
      busy          <= 1'b0;
      done          <= 1'b0;
      checksum      <= 32'h0;
    end else begin
      write_enable <= 4'h0;
      rd_pipe      <= {rd_pipe[READ_LATENCY-1:0], issue};
      if (sample) begin
        checksum <= checksum + read_data;
        smp_idx  <= smp_idx + 16'd1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            base     <= base_address;
            count    <= word_count;
            checksum <= 32'h0;
            lane     <= 2'd0;
            wr_idx   <= 16'h0;
            rd_idx   <= 16'h0;
            smp_idx  <= 16'h0;
            rd_pipe  <= '0;
            if (word_count != 16'h0) begin
              state      <= S_LOAD;
              busy       <= 1'b1;
              byte_ready <= 1'b1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (accept) begin
            if (lane == 2'd3) begin
              write_enable  <= 4'hF;
              write_data    <= {byte_data, partial};
              write_address <= base + {16'h0, wr_idx};
              lane          <= 2'd0;
              wr_idx        <= wr_idx + 16'd1;
              if (last_word) begin
                byte_ready <= 1'b0;
                state      <= S_READBACK;
              end
            end else begin
              case (lane)
                2'd0:    partial[7:0]   <= byte_data;
                2'd1:    partial[15:8]  <= byte_data;
                default: partial[23:16] <= byte_data;
              endcase
              lane <= lane + 2'd1;
            end
          end
        end

        S_READBACK: begin
          if (issue) begin
            read_address <= base + {16'h0, rd_idx};
            rd_idx       <= rd_idx + 16'd1;
          end
          if (sample && (smp_idx == count - 16'd1)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: an echoing memory model plus expectations derived from the byte stream
// (word packing, write/read schedule, running sums) for directed and random loads.
module tb_mem_loader;
  localparam int RL = 3;
  localparam int TN = 8192;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_address = 32'h0;
  logic [15:0] word_count = 16'h0;
  logic [7:0]  byte_data = 8'h0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic [3:0]  write_enable;
  logic [31:0] read_address;
  logic [31:0] read_data = 32'h0;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  always #5 clock = ~clock;

  mem_loader #(.READ_LATENCY(RL)) dut (
    .clock(clock), .reset(reset), .start(start),
    .base_address(base_address), .word_count(word_count),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .write_address(write_address), .write_data(write_data), .write_enable(write_enable),
    .read_address(read_address), .read_data(read_data),
    .busy(busy), .done(done), .checksum(checksum)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] dl [0:RL];
  logic        busy_tr [TN];
  logic        done_tr [TN];
  logic        br_tr [TN];
  logic [3:0]  we_tr [TN];
  logic [31:0] wa_tr [TN];
  logic [31:0] wd_tr [TN];
  logic [31:0] ra_tr [TN];
  logic [31:0] ck_tr [TN];
  logic [7:0]  bq [$];
  int          acc [$];

  always @(posedge clock) cyc = cyc + 1;

  // Trace recorder and memory: writes land immediately, reads return RL cycles after the address.
  always @(negedge clock) begin
    if (cyc < TN) begin
      busy_tr[cyc] = busy;
      done_tr[cyc] = done;
      br_tr[cyc]   = byte_ready;
      we_tr[cyc]   = write_enable;
      wa_tr[cyc]   = write_address;
      wd_tr[cyc]   = write_data;
      ra_tr[cyc]   = read_address;
      ck_tr[cyc]   = checksum;
    end
    if (!reset && write_enable == 4'hF) mem[write_address] = write_data;
    for (int k = RL; k > 0; k--) dl[k] = dl[k-1];
    dl[0] = mem.exists(read_address) ? mem[read_address] : 32'h0;
    read_data = dl[RL];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int i);
    return {bq[4*i+3], bq[4*i+2], bq[4*i+1], bq[4*i]};
  endfunction

  task automatic fill_random(input int count);
    bq.delete();
    for (int i = 0; i < 4*count; i++) bq.push_back(8'($urandom));
  endtask

  task automatic run_load(input logic [31:0] base, input int count, input int gap,
                          input bit spur, input string tag);
    int sc, wl, de, k, budget, nw, nd, nb, wc;
    logic [31:0] sum, part;
    acc.delete();
    @(negedge clock);
    chk({tag, ".ready_idle"}, 32'(byte_ready), 32'h0);
    start = 1'b1; base_address = base; word_count = count[15:0];
    byte_valid = 1'b1; byte_data = 8'hA5;
    sc = cyc;
    @(negedge clock);
    start = 1'b0;
    k = 0; budget = 0;
    while (k < 4*count && budget < 4000) begin
      start = spur && (k == 2);
      if (start) begin base_address = ~base; word_count = count[15:0] + 16'd3; end
      byte_valid = ($urandom_range(99) >= gap);
      byte_data = byte_valid ? bq[k] : 8'($urandom);
      if (byte_valid && byte_ready) begin acc.push_back(cyc); k++; end
      @(negedge clock);
      budget++;
    end
    byte_valid = 1'b0; start = 1'b0;
    chk({tag, ".bytes_taken"}, 32'(k), 32'(4*count));
    if (k != 4*count) return;

    wl = (count == 0) ? sc : acc[4*count-1] + 1;
    de = (count == 0) ? sc + 1 : wl + count + RL + 1;
    while (cyc <= de + 3) @(negedge clock);

    sum = 32'h0;
    for (int i = 0; i < count; i++) begin
      wc = acc[4*i+3] + 1;
      chk({tag, ".we"}, 32'(we_tr[wc]), 32'hF);
      chk({tag, ".waddr"}, wa_tr[wc], base + 32'(i));
      chk({tag, ".wdata"}, wd_tr[wc], word_at(i));
      sum += word_at(i);
    end
    part = 32'h0;
    for (int i = 0; i < count; i++) begin
      chk({tag, ".raddr"}, ra_tr[wl+1+i], base + 32'(i));
      chk({tag, ".ck_before"}, ck_tr[wl+1+i+RL], part);
      part += word_at(i);
      chk({tag, ".ck_after"}, ck_tr[wl+2+i+RL], part);
    end
    nw = 0; nd = 0; nb = 0;
    for (int c = sc; c <= de + 2; c++) begin
      if (we_tr[c] != 4'h0) nw++;
      if (done_tr[c]) nd++;
      if (busy_tr[c]) nb++;
    end
    chk({tag, ".n_writes"}, 32'(nw), 32'(count));
    chk({tag, ".n_done"}, 32'(nd), 32'd1);
    chk({tag, ".n_busy"}, 32'(nb), 32'(de - sc - 1));
    chk({tag, ".done_at"}, 32'(done_tr[de]), 32'd1);
    chk({tag, ".busy_done"}, 32'(busy_tr[de]), 32'd0);
    chk({tag, ".ck_clear"}, ck_tr[sc+1], 32'h0);
    chk({tag, ".ck_final"}, ck_tr[de], sum);
    chk({tag, ".ck_hold"}, ck_tr[de+2], sum);
    if (count > 0) begin
      chk({tag, ".ready_load"}, 32'(br_tr[sc+1]), 32'd1);
      chk({tag, ".ready_off"}, 32'(br_tr[wl]), 32'd0);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".byte_ready"}, 32'(byte_ready), 32'h0);
    chk({tag, ".we"}, 32'(write_enable), 32'h0);
    chk({tag, ".waddr"}, write_address, 32'h0);
    chk({tag, ".wdata"}, write_data, 32'h0);
    chk({tag, ".raddr"}, read_address, 32'h0);
    chk({tag, ".busy"}, 32'(busy), 32'h0);
    chk({tag, ".done"}, 32'(done), 32'h0);
    chk({tag, ".checksum"}, checksum, 32'h0);
  endtask

  initial begin
    int sr, nw;
    for (int k = 0; k <= RL; k++) dl[k] = 32'h0;

    #1 reset = 1'b1;
    #1 check_zero("por");
    @(negedge clock); @(negedge clock);
    reset = 1'b0;

    bq = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load(32'h10, 1, 0, 1'b0, "single");

    bq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
    run_load(32'h10, 2, 40, 1'b0, "gaps");

    bq.delete();
    run_load(32'h40, 0, 0, 1'b0, "zero");

    fill_random(3);
    run_load(32'h80, 3, 30, 1'b1, "spur_start");

    // Reset after two bytes of a three-word load
    @(negedge clock);
    start = 1'b1; base_address = 32'h200; word_count = 16'd3;
    @(negedge clock);
    start = 1'b0; byte_valid = 1'b1; byte_data = 8'hDE;
    @(negedge clock);
    byte_data = 8'hAD;
    @(negedge clock);
    byte_valid = 1'b0;
    @(posedge clock);
    #2 reset = 1'b1;
    #1 check_zero("mid_reset");
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    sr = cyc;
    repeat (8) @(negedge clock);
    nw = 0;
    for (int c = sr - 2; c <= sr + 6; c++) if (we_tr[c] != 4'h0) nw++;
    chk("mid_reset.no_strobe", 32'(nw), 32'h0);
    bq = '{8'h5A, 8'hC3, 8'h0F, 8'hF0};
    run_load(32'h300, 1, 0, 1'b0, "after_reset");

    fill_random(2);
    run_load(32'hFFFF_FFFF, 2, 20, 1'b0, "wrap");

    for (int n = 0; n < 4; n++) begin
      int cnt;
      cnt = $urandom_range(6, 1);
      fill_random(cnt);
      run_load($urandom, cnt, $urandom_range(50, 0), 1'b0, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 1, cycles from read_address to valid read_data (legal 1..4).
REQ-002 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a load, sampled only in IDLE.
REQ-005 SHALL have port base_address  input  32  word address of first word, sampled with start.
REQ-006 SHALL have port word_count  input  16  number of 32-bit words to load, sampled with start.
REQ-007 SHALL have port byte_data  input  8  incoming payload byte.
REQ-008 SHALL have port byte_valid  input  1  byte_data valid.
REQ-009 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port write_address  output  32  memory word write address.
REQ-011 SHALL have port write_data  output  32  memory write data.
REQ-012 SHALL have port write_enable  output  4  per-byte memory write strobes.
REQ-013 SHALL have port read_address  output  32  memory word read address.
REQ-014 SHALL have port read_data  input  32  memory read data, READ_LATENCY cycles after read_address.
REQ-015 SHALL have port busy  output  1  high in LOAD and READBACK.
REQ-016 SHALL have port done  output  1  one-cycle completion pulse.
REQ-017 SHALL have port checksum  output  32  mod-2^32 sum of read-back words.

Function
REQ-018 SHALL implement states IDLE, LOAD, READBACK, DONE; all outputs registered.
REQ-019 IDLE: start=1 latches base_address/word_count, clears checksum; word_count!=0 -> LOAD, word_count==0 -> DONE.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 LOAD: byte_ready=1 every cycle; byte accepted iff byte_valid && byte_ready; no backpressure from writes.
REQ-022 Bytes SHALL pack little-endian: byte n of a word -> bits 8n+7:8n, n=0..3.
REQ-023 Cycle after 4th byte of word i accepted: write_enable=4'hF, write_address=base+i, write_data=assembled word, for exactly one cycle; otherwise write_enable=4'h0.
REQ-024 Address arithmetic SHALL wrap modulo 2^32; no address is special-cased.
REQ-025 After last word accepted: byte_ready=0 next cycle, enter READBACK the cycle the last write is presented.
REQ-026 READBACK: issue read_address=base+i for i=0..word_count-1 on consecutive cycles, first issue one cycle after last write.
REQ-027 Each read_data SHALL be added to checksum exactly READ_LATENCY cycles after its address (valid-bit shift register); word_count samples total.
REQ-028 After last sample accumulated -> DONE; DONE lasts one cycle with done=1, busy=0, then IDLE.
REQ-029 checksum SHALL hold its final value in IDLE until the next accepted start.
REQ-030 busy SHALL be 1 from the cycle after accepted start through the last READBACK cycle.
REQ-031 Bytes presented outside LOAD SHALL not be consumed (byte_ready=0).

Reset
REQ-032 reset=1 SHALL asynchronously force IDLE, byte_ready=0, write_enable=0, write_address=0, write_data=0, read_address=0, busy=0, done=0, checksum=0, and discard any partial word and pending read samples.
REQ-033 Reset mid-LOAD or mid-READBACK SHALL leave no write strobe asserted after reset rises.

Verification
REQ-034 Reset: assert reset asynchronously mid-cycle -> all outputs 0 immediately, state IDLE.
REQ-035 start base=0x10 count=1, bytes 0x11,0x22,0x33,0x44 back-to-back, memory model echoes writes -> one write 0x10/0x44332211/4'hF, one read of 0x10, checksum=0x44332211, done single pulse.
REQ-036 count=2 with byte_valid gaps, stored words 0xFFFFFFFF and 0x00000002 -> writes at 0x10,0x11 only on 4th-byte cycles, checksum=0x00000001.
REQ-037 count=0 -> DONE one cycle after start, done=1, no write_enable, checksum=0.
REQ-038 start pulsed during LOAD -> ignored, counts unchanged; reset after 2 bytes -> write_enable stays 0, next load starts at byte lane 0.
REQ-039 base=0xFFFFFFFF count=2, READ_LATENCY=3 -> write/read addresses 0xFFFFFFFF then 0x00000000, checksum sampled 3 cycles after each read address.
